// File: rtl/xbar_pkg.sv
// Shared definitions for the 1-to-3 crossbar: the slave address map, response codes,
// the read/write FSM state types and a select-to-one-hot helper.
package xbar_pkg;

  localparam int NSLV = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Entry i is slave i: 0 = SRAM, 1 = UART, 2 = CLINT. Limits are inclusive.
  localparam logic [NSLV-1:0][31:0] SLV_BASE  = {32'hA000_0048, 32'hA000_03F8, 32'h8000_0000};
  localparam logic [NSLV-1:0][31:0] SLV_LIMIT = {32'hA000_004F, 32'hA000_03FF, 32'h87FF_FFFF};

  typedef enum logic [2:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_ERR,
    R_ERESP
  } rstate_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_FWD,
    W_RESP,
    W_ERR,
    W_ERESP
  } wstate_e;

  function automatic logic [NSLV-1:0] sel2oh(input logic [1:0] sel);
    sel2oh = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == 2'(i)) sel2oh[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/xbar_decode.sv
// Combinational address decoder: maps an address onto {hit, slave index}.
// Unmapped addresses give hit=0 and index 0.
module xbar_decode
  import xbar_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [1:0]        idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = 2'd0;
    for (int i = 0; i < NSLV; i++) begin
      if (addr_i >= ADDR_W'(SLV_BASE[i]) && addr_i <= ADDR_W'(SLV_LIMIT[i])) begin
        hit_o = 1'b1;
        idx_o = 2'(i);
      end
    end
  end

endmodule

// File: rtl/xbar_1to3.sv
// One-master, three-slave AXI-lite style crossbar with independent read and write FSMs.
// Unmapped accesses are answered locally with DECERR.
module xbar_1to3
  import xbar_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [ADDR_W-1:0]             m_araddr,
  input  logic                          m_arvalid,
  output logic                          m_arready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic                          m_rvalid,
  input  logic                          m_rready,
  input  logic [ADDR_W-1:0]             m_awaddr,
  input  logic                          m_awvalid,
  output logic                          m_awready,
  input  logic [DATA_W-1:0]             m_wdata,
  input  logic [DATA_W/8-1:0]           m_wstrb,
  input  logic                          m_wvalid,
  output logic                          m_wready,
  output logic [1:0]                    m_bresp,
  output logic                          m_bvalid,
  input  logic                          m_bready,

  output logic [NSLV*ADDR_W-1:0]        s_araddr,
  output logic [NSLV-1:0]               s_arvalid,
  input  logic [NSLV-1:0]               s_arready,
  input  logic [NSLV*DATA_W-1:0]        s_rdata,
  input  logic [2*NSLV-1:0]             s_rresp,
  input  logic [NSLV-1:0]               s_rvalid,
  output logic [NSLV-1:0]               s_rready,
  output logic [NSLV*ADDR_W-1:0]        s_awaddr,
  output logic [NSLV-1:0]               s_awvalid,
  input  logic [NSLV-1:0]               s_awready,
  output logic [NSLV*DATA_W-1:0]        s_wdata,
  output logic [NSLV*(DATA_W/8)-1:0]    s_wstrb,
  output logic [NSLV-1:0]               s_wvalid,
  input  logic [NSLV-1:0]               s_wready,
  input  logic [2*NSLV-1:0]             s_bresp,
  input  logic [NSLV-1:0]               s_bvalid,
  output logic [NSLV-1:0]               s_bready
);

  localparam int STRB_W = DATA_W / 8;

  rstate_e             rstate_q, rstate_d;
  wstate_e             wstate_q, wstate_d;
  logic [1:0]          rsel_q, rsel_d;
  logic [1:0]          wsel_q, wsel_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                aw_hs, w_hs;

  logic                ar_hit, aw_hit;
  logic [1:0]          ar_idx, aw_idx;
  logic [NSLV-1:0]     rsel_oh, wsel_oh;
  logic [DATA_W-1:0]   sel_rdata;
  logic [1:0]          sel_rresp, sel_bresp;

  xbar_decode #(.ADDR_W(ADDR_W)) u_ar_decode (
    .addr_i (m_araddr),
    .hit_o  (ar_hit),
    .idx_o  (ar_idx)
  );

  xbar_decode #(.ADDR_W(ADDR_W)) u_aw_decode (
    .addr_i (m_awaddr),
    .hit_o  (aw_hit),
    .idx_o  (aw_idx)
  );

  assign rsel_oh = sel2oh(rsel_q);
  assign wsel_oh = sel2oh(wsel_q);

  always_comb begin
    sel_rdata = '0;
    sel_rresp = RESP_OKAY;
    sel_bresp = RESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      if (rsel_oh[i]) begin
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
        sel_rresp = s_rresp[2*i +: 2];
      end
      if (wsel_oh[i]) sel_bresp = s_bresp[2*i +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      wstate_q  <= W_IDLE;
      rsel_q    <= 2'd0;
      wsel_q    <= 2'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      wstate_q  <= wstate_d;
      rsel_q    <= rsel_d;
      wsel_q    <= wsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read path; outputs are forced quiet while rst is high.
  always_comb begin
    rstate_d  = rstate_q;
    rsel_d    = rsel_q;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = RESP_OKAY;
    s_arvalid = '0;
    s_araddr  = '0;
    s_rready  = '0;
    if (!rst) begin
      case (rstate_q)
        R_IDLE: begin
          if (m_arvalid) begin
            rsel_d   = ar_idx;
            rstate_d = ar_hit ? R_ADDR : R_ERR;
          end
        end
        R_ADDR: begin
          s_arvalid = rsel_oh & {NSLV{m_arvalid}};
          for (int i = 0; i < NSLV; i++) begin
            if (rsel_oh[i]) s_araddr[i*ADDR_W +: ADDR_W] = m_araddr;
          end
          m_arready = |(s_arready & rsel_oh);
          if (m_arvalid && m_arready) rstate_d = R_DATA;
        end
        R_DATA: begin
          m_rvalid = |(s_rvalid & rsel_oh);
          m_rdata  = sel_rdata;
          m_rresp  = sel_rresp;
          s_rready = rsel_oh & {NSLV{m_rready}};
          if (m_rvalid && m_rready) rstate_d = R_IDLE;
        end
        R_ERR: begin
          m_arready = 1'b1;
          rstate_d  = R_ERESP;
        end
        R_ERESP: begin
          m_rvalid = 1'b1;
          m_rresp  = RESP_DECERR;
          if (m_rready) rstate_d = R_IDLE;
        end
        default: rstate_d = R_IDLE;
      endcase
    end
  end

  // Write path; AW and W complete independently, tracked by the sticky done flags.
  always_comb begin
    wstate_d  = wstate_q;
    wsel_d    = wsel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = RESP_OKAY;
    s_awvalid = '0;
    s_awaddr  = '0;
    s_wvalid  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_bready  = '0;
    if (!rst) begin
      case (wstate_q)
        W_IDLE: begin
          if (m_awvalid) begin
            wsel_d   = aw_idx;
            wstate_d = aw_hit ? W_FWD : W_ERR;
          end
        end
        W_FWD: begin
          s_awvalid = wsel_oh & {NSLV{m_awvalid & ~aw_done_q}};
          s_wvalid  = wsel_oh & {NSLV{m_wvalid & ~w_done_q}};
          for (int i = 0; i < NSLV; i++) begin
            if (wsel_oh[i]) begin
              s_awaddr[i*ADDR_W +: ADDR_W] = m_awaddr;
              s_wdata[i*DATA_W +: DATA_W]  = m_wdata;
              s_wstrb[i*STRB_W +: STRB_W]  = m_wstrb;
            end
          end
          m_awready = |(s_awready & wsel_oh) & ~aw_done_q;
          m_wready  = |(s_wready & wsel_oh) & ~w_done_q;
        end
        W_RESP: begin
          m_bvalid = |(s_bvalid & wsel_oh);
          m_bresp  = sel_bresp;
          s_bready = wsel_oh & {NSLV{m_bready}};
          if (m_bvalid && m_bready) wstate_d = W_IDLE;
        end
        W_ERR: begin
          m_awready = m_awvalid & ~aw_done_q;
          m_wready  = m_wvalid & ~w_done_q;
        end
        W_ERESP: begin
          m_bvalid = 1'b1;
          m_bresp  = RESP_DECERR;
          if (m_bready) wstate_d = W_IDLE;
        end
        default: wstate_d = W_IDLE;
      endcase
      if (wstate_q == W_FWD || wstate_q == W_ERR) begin
        aw_hs = m_awvalid & m_awready;
        w_hs  = m_wvalid & m_wready;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = (wstate_q == W_FWD) ? W_RESP : W_ERESP;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_1to3.sv
// Directed scoreboard bench for xbar_1to3: slaves are modelled as always-ready sources
// with distinct per-slave data/resp so any mis-routing shows up in the compared values.
module tb_xbar_1to3;

  logic        clk;
  logic        rst;
  logic [31:0] m_araddr;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [95:0] s_araddr;
  logic [2:0]  s_arvalid, s_arready;
  logic [95:0] s_rdata;
  logic [5:0]  s_rresp;
  logic [2:0]  s_rvalid, s_rready;
  logic [95:0] s_awaddr;
  logic [2:0]  s_awvalid, s_awready;
  logic [95:0] s_wdata;
  logic [11:0] s_wstrb;
  logic [2:0]  s_wvalid, s_wready;
  logic [5:0]  s_bresp;
  logic [2:0]  s_bvalid, s_bready;

  int checks = 0;
  int errors = 0;

  logic [33:0] rdExpQ[$];
  logic [1:0]  wrExpQ[$];

  logic [2:0][31:0] slvData = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
  logic [2:0][1:0]  slvRResp = {2'b10, 2'b01, 2'b00};
  logic [2:0][1:0]  slvBResp = {2'b10, 2'b01, 2'b00};

  xbar_1to3 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic failNow(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed timeout/empty expected event", tag);
  endtask

  task automatic applyStimulus();
    s_arready = 3'b111;
    s_rvalid  = 3'b111;
    s_rdata   = slvData;
    s_rresp   = slvRResp;
    s_awready = 3'b111;
    s_wready  = 3'b111;
    s_bvalid  = 3'b111;
    s_bresp   = slvBResp;
    m_araddr  = '0; m_arvalid = 1'b0; m_rready = 1'b0;
    m_awaddr  = '0; m_awvalid = 1'b0;
    m_wdata   = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b0;
  endtask

  // sl < 0 means the address is unmapped and a DECERR is expected.
  task automatic doRead(input logic [31:0] addr, input int sl);
    logic [33:0] e;
    logic [2:0]  orAr = '0;
    logic [2:0]  mask;
    int          arCnt = 0;
    bit          done = 0;
    bit          arNow;
    mask = (sl < 0) ? 3'b000 : 3'(1 << sl);
    rdExpQ.push_back((sl < 0) ? {2'b11, 32'h0} : {slvRResp[sl], slvData[sl]});
    @(posedge clk); #1;
    m_araddr = addr; m_arvalid = 1'b1; m_rready = 1'b1;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      orAr |= s_arvalid;
      if (cyc == 0) checkOutput("ar_decode_cycle", 96'(m_arready), 96'(0));
      arNow = m_arvalid && m_arready;
      if (m_arready) arCnt++;
      if (arNow && sl >= 0) checkOutput("s_araddr", s_araddr, 96'(addr) << (32 * sl));
      if (m_rvalid) begin
        if (rdExpQ.size() == 0) failNow("rd_scoreboard_empty");
        else begin
          e = rdExpQ.pop_front();
          checkOutput("m_rdata", 96'(m_rdata), 96'(e[31:0]));
          checkOutput("m_rresp", 96'(m_rresp), 96'(e[33:32]));
        end
        checkOutput("s_rready", 96'(s_rready), 96'(mask));
        done = 1;
      end
      @(posedge clk); #1;
      if (arNow) m_arvalid = 1'b0;
      if (done) m_rready = 1'b0;
    end
    if (!done) failNow("read_timeout");
    m_arvalid = 1'b0; m_rready = 1'b0;
    checkOutput("ar_pulses", 96'(arCnt), 96'(1));
    checkOutput("s_arvalid_mask", 96'(orAr), 96'(mask));
  endtask

  // wLead > 0: W is raised wLead cycles after the AW handshake while AW valid is held.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int sl, input int wLead, input logic [1:0] bExp);
    bit          awHs = 0, wHs = 0, bHs = 0, awNow, wNow;
    int          awCyc = 0;
    logic [2:0]  orAw = '0, orW = '0, mask;
    logic [1:0]  e;
    mask = (sl < 0) ? 3'b000 : 3'(1 << sl);
    wrExpQ.push_back(bExp);
    @(posedge clk); #1;
    m_awaddr = addr; m_awvalid = 1'b1; m_wdata = data; m_wstrb = strb;
    m_wvalid = (wLead == 0); m_bready = 1'b1;
    for (int cyc = 0; cyc < 30 && !bHs; cyc++) begin
      @(negedge clk);
      orAw |= s_awvalid;
      orW  |= s_wvalid;
      if (cyc == 0) checkOutput("aw_decode_cycle", 96'({m_awready, m_wready}), 96'(0));
      if (awHs && !wHs) checkOutput("aw_done_hold", 96'({m_awready, s_awvalid}), 96'(0));
      if (m_bvalid) begin
        checkOutput("b_after_w", 96'(wHs), 96'(1));
        if (wrExpQ.size() == 0) failNow("wr_scoreboard_empty");
        else begin
          e = wrExpQ.pop_front();
          checkOutput("m_bresp", 96'(m_bresp), 96'(e));
        end
        checkOutput("s_bready", 96'(s_bready), 96'(mask));
        bHs = 1;
      end
      awNow = m_awvalid && m_awready && !awHs;
      wNow  = m_wvalid && m_wready;
      if (awNow) begin
        awCyc = cyc;
        if (sl >= 0) checkOutput("s_awaddr", s_awaddr, 96'(addr) << (32 * sl));
      end
      if (wNow && sl >= 0) begin
        checkOutput("s_wdata", s_wdata, 96'(data) << (32 * sl));
        checkOutput("s_wstrb", 96'(s_wstrb), 96'(strb) << (4 * sl));
      end
      @(posedge clk); #1;
      if (awNow) awHs = 1;
      if (awNow && wLead == 0) m_awvalid = 1'b0;
      if (wNow) begin
        wHs = 1;
        m_wvalid  = 1'b0;
        m_awvalid = 1'b0;
      end
      if (awHs && !wHs && wLead > 0 && cyc == awCyc + wLead - 1) m_wvalid = 1'b1;
      if (bHs) m_bready = 1'b0;
    end
    if (!bHs) failNow("write_timeout");
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
    checkOutput("s_awvalid_mask", 96'(orAw), 96'(mask));
    checkOutput("s_wvalid_mask", 96'(orW), 96'(mask));
  endtask

  initial begin
    bit arSeen;
    $display("[TB] start");
    applyStimulus();
    rst = 1'b1;
    m_arvalid = 1'b1;
    m_awvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_handshakes", 96'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 96'(0));
    checkOutput("rst_mdata", 96'({m_rdata, m_rresp, m_bresp}), 96'(0));
    checkOutput("rst_saddr", s_araddr | s_awaddr | s_wdata | 96'(s_wstrb), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0; m_arvalid = 1'b0; m_awvalid = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_rst", 96'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                s_arvalid, s_awvalid, s_wvalid}), 96'(0));

    // Reads: SRAM example, map boundaries and unmapped holes.
    doRead(32'h8000_0010, 0);
    doRead(32'h9000_0000, -1);
    doRead(32'h87FF_FFFF, 0);
    doRead(32'h8800_0000, -1);
    doRead(32'h7FFF_FFFF, -1);
    doRead(32'hA000_03F8, 1);
    doRead(32'hA000_03FF, 1);
    doRead(32'hA000_0400, -1);
    doRead(32'hA000_0048, 2);
    doRead(32'hA000_004F, 2);
    doRead(32'hA000_0047, -1);

    // W without AW must not be accepted.
    @(posedge clk); #1;
    m_wvalid = 1'b1; m_wdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      checkOutput("w_only_wait", 96'({m_wready, s_wvalid, s_awvalid}), 96'(0));
      @(posedge clk); #1;
    end
    m_wvalid = 1'b0;

    // Writes: UART example, CLINT with AW leading W, DECERR variants.
    doWrite(32'hA000_03F8, 32'h0000_0041, 4'h1, 1, 0, slvBResp[1]);
    doWrite(32'hA000_0048, 32'h1234_5678, 4'hF, 2, 3, slvBResp[2]);
    doWrite(32'h8000_0000, 32'hCAFE_F00D, 4'hC, 0, 1, slvBResp[0]);
    doWrite(32'hA000_004F, 32'h0BAD_0BAD, 4'h3, 2, 0, slvBResp[2]);
    doWrite(32'h0000_1000, 32'h5555_5555, 4'hF, -1, 0, 2'b11);
    doWrite(32'hA000_0400, 32'h6666_6666, 4'hF, -1, 2, 2'b11);

    // Concurrent read (SRAM) and write (UART).
    fork
      doRead(32'h8000_0100, 0);
      doWrite(32'hA000_03FC, 32'h0000_005A, 4'h1, 1, 0, slvBResp[1]);
    join

    // Reset while parked in R_DATA with slave0 rvalid high.
    @(posedge clk); #1;
    m_araddr = 32'h8000_0020; m_arvalid = 1'b1; m_rready = 1'b0;
    arSeen = 0;
    for (int c = 0; c < 10 && !arSeen; c++) begin
      @(negedge clk);
      if (m_arvalid && m_arready) arSeen = 1;
      @(posedge clk); #1;
    end
    m_arvalid = 1'b0;
    if (!arSeen) failNow("rst_test_ar_timeout");
    @(negedge clk);
    checkOutput("pre_rst_rvalid", 96'(m_rvalid), 96'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rvalid", 96'({m_rvalid, s_rready}), 96'(0));
    doRead(32'h8000_0010, 0);

    if (rdExpQ.size() != 0 || wrExpQ.size() != 0) failNow("scoreboard_leftover");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
